psum_accumulator: RTL
=====================

Name: psum_accumulator

Overview:
- Consumer end of the multiplier/adder-tree datapath.
- Accepts the registered final-level tree sum, one beat per tile, and accumulates cfg_tiles consecutive beats into one dot-product result.
- Buffers finished results in a small FIFO and drains them downstream over a valid/ready handshake.
- Supports dot products longer than one LENGTH-wide tile.

Parameters:
- IN_W, 16, width of incoming tree sum (INT16), signed two's complement
- ACC_W, 32, accumulator and result width, signed; must be >= IN_W
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2
- CNT_W, 8, width of cfg_tiles and beat counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_tiles  input  CNT_W  beats per result; sampled on first beat of each result
- in_valid  input  1  in_sum valid this cycle
- in_ready  output  1  block can accept a beat this cycle
- in_sum  input  IN_W  adder-tree output sum, signed
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  downstream accepts out_data
- out_data  output  ACC_W  accumulated result, signed
- busy  output  1  partial result in progress (state ACCUM)
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  results held in FIFO

Behaviour:
- Reset values, async, immediate on reset high:
  - state = IDLE, acc = 0, beat counter = 0, latched tiles = 1
  - FIFO empty, fifo_cnt = 0, out_valid = 0, out_data = 0, busy = 0
  - in_ready = 1 once FIFO is empty
- Beat accepted when in_valid && in_ready; in_ready = (fifo_cnt != FIFO_DEPTH). No same-cycle pop-to-push bypass: if FIFO is full, in_ready is low even when a pop occurs that cycle.
- Arithmetic: in_sum sign-extended to ACC_W; sum = acc_base + sext(in_sum), wrapping mod 2^ACC_W. acc_base = 0 on the first beat of a result, else acc.
- State IDLE:
  - Accepted beat latches T = (cfg_tiles == 0) ? 1 : cfg_tiles.
  - If T == 1: push sext(in_sum) to FIFO, stay in IDLE.
  - Else: acc <= sext(in_sum), counter <= 1, go to ACCUM.
- State ACCUM:
  - cfg_tiles is ignored.
  - Accepted beat with counter == T-1: push sum to FIFO, acc <= 0, counter <= 0, go to IDLE.
  - Other accepted beat: acc <= sum, counter++.
  - No beat: hold all state.
- in_valid is ignored while in_ready = 0; in_sum need not be held stable by the producer on those cycles, because the tree output is registered. Upstream stalls the tree when in_ready = 0.
- FIFO:
  - Circular buffer with read/write pointers wrapping at FIFO_DEPTH.
  - out_valid = (fifo_cnt != 0); out_data = head entry, registered storage, 0 when empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_cnt unchanged and is legal when non-empty.
  - Pop while empty is ignored.
- Latency: the final beat accepted at cycle N gives out_valid = 1 at N+1 when the FIFO was empty. Back-to-back T = 1 beats give one result per cycle.
- busy = (state == ACCUM).
- A reset mid-result discards the partial acc and all FIFO contents; no output is produced for the aborted result.

Optional Feature:
- Macro: PSUM_SATURATE_EN.
- Defined: each accumulate clamps to the signed ACC_W range.
  - Positive overflow gives 2^(ACC_W-1)-1; negative overflow gives -2^(ACC_W-1).
  - The clamp is applied on every beat, including the final one.
  - Adds output sat_flag (1 bit) per FIFO entry, presented alongside out_data; it is 1 if any beat of that result saturated, 0 at reset.
- Undefined: plain wrap-around arithmetic; the sat_flag port does not exist.

Test Plan:
- Reset, then cfg_tiles=3, beats 100, -20, 7 with out_ready=1 -> one out_data=87, out_valid pulses one cycle after the third beat, busy high for 2 cycles.
- cfg_tiles=0 and cfg_tiles=1, beats 0x7FFF then 0x8000 -> results 32767 then -32768 on consecutive cycles, busy stays 0.
- out_ready=0, cfg_tiles=1, 6 beats offered -> 4 accepted, in_ready=0 after 4th, fifo_cnt=4. Raising out_ready drains in order, and beats 5-6 are accepted only from the cycle after the first pop.
- cfg_tiles changed from 2 to 5 mid-result (beats 10, 11) -> result 21 uses latched T=2; the next result uses T=5.
- Assert reset after 2 of 4 beats (values 50, 60), then run cfg_tiles=1 beat 9 -> only result 9 appears, no 110.
- PSUM_SATURATE_EN, ACC_W=16, cfg_tiles=2, beats 0x7000, 0x7000 -> out_data=0x7FFF, sat_flag=1. Without the macro -> out_data=0xE000.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums cfg_tiles adder-tree beats into one dot-product result and queues
// results in a small FIFO drained over valid/ready. Define PSUM_SATURATE_EN for clamping + sat_flag.
module psum_accumulator #(
  parameter int IN_W       = 16,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            cfg_tiles,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_sum,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        busy,
`ifdef PSUM_SATURATE_EN
  output logic                        sat_flag,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FCNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     tiles_q, tiles_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       fcnt_q, fcnt_d;
  logic [ACC_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ACC_W-1:0]     mem_d [FIFO_DEPTH];

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     tiles_new;
  logic [ACC_W-1:0]     in_ext;
  logic [ACC_W-1:0]     acc_base;
  logic [ACC_W-1:0]     sum;

  assign in_ready = (fcnt_q != FULL_CNT);
  assign accept   = in_valid && in_ready;
  assign pop      = (fcnt_q != '0) && out_ready;
  assign in_ext   = ACC_W'($signed(in_sum));
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;

`ifdef PSUM_SATURATE_EN
  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0]   wide;
  logic             ovf;
  logic             beat_flag;
  logic             sat_acc_q, sat_acc_d;
  logic             flag_q [FIFO_DEPTH];
  logic             flag_d [FIFO_DEPTH];

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign wide = {acc_base[ACC_W-1], acc_base} + {in_ext[ACC_W-1], in_ext};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum  = ovf ? (wide[ACC_W] ? MIN_NEG : MAX_POS) : wide[ACC_W-1:0];

  always_comb begin
    beat_flag = ((state_q == ACCUM) && sat_acc_q) || ovf;
    sat_acc_d = sat_acc_q;
    if (accept) sat_acc_d = push ? 1'b0 : beat_flag;
    flag_d = flag_q;
    if (push) flag_d[wr_ptr_q] = beat_flag;
  end

  assign sat_flag = (fcnt_q != '0) ? flag_q[rd_ptr_q] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_acc_q <= 1'b0;
      flag_q    <= '{default: 1'b0};
    end else begin
      sat_acc_q <= sat_acc_d;
      flag_q    <= flag_d;
    end
  end
`else
  assign sum = acc_base + in_ext;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tiles_d   = tiles_q;
    push      = 1'b0;
    tiles_new = (cfg_tiles == '0) ? CNT_ONE : cfg_tiles;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tiles_d = tiles_new;
          if (tiles_new == CNT_ONE) begin
            push = 1'b1;
          end else begin
            acc_d   = sum;
            cnt_d   = CNT_ONE;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        // cfg_tiles is deliberately ignored here; the count latched on the first beat rules.
        if (accept) begin
          if (cnt_q == tiles_q - CNT_ONE) begin
            push    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = sum;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_ONE;
      2'b01:   fcnt_d = fcnt_q - FCNT_ONE;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      tiles_q  <= CNT_ONE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tiles_q  <= tiles_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      mem_q    <= mem_d;
    end
  end

  assign out_valid = (fcnt_q != '0);
  assign out_data  = (fcnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign busy      = (state_q == ACCUM);
  assign fifo_cnt  = fcnt_q;

endmodule
